// File: rtl/irq_aggregator.sv
// Purpose : Avalon-MM interrupt controller; captures NUM_IRQ lines (level or rising-edge) into
//           pending bits, masks them and drives one registered irq to the CPU.
// Latency : irq_in high before edge k -> pending at edge k -> irq high after edge k+1; read latency 1.
// Flow    : no backpressure; the slave accepts every access in a single cycle.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   address[2:0]        word address (0 STATUS, 1 PENDING, 2 MASK, 3 EDGE_SEL, 4 VECTOR, 5 ACK)
//   chipselect, write_n slave select and active-low write strobe
//   writedata[15:0]     write data
//   readdata[15:0]      registered read data, valid one cycle after the request
//   irq_in[NUM_IRQ-1:0] peripheral interrupt lines, synchronous to clk (bit 0 = timer)
//   irq                 aggregated, registered interrupt to the CPU

module irq_aggregator #(
  parameter int                 NUM_IRQ    = 8,
  parameter logic [NUM_IRQ-1:0] RESET_EDGE = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_EDGE    = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_ACK     = 3'd5;

  // Line registers
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] edge_sel;
  logic [NUM_IRQ-1:0] irq_d;

  // Per-cycle decode
  logic               wr;
  logic [NUM_IRQ-1:0] wd_lines;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] hw_set;
  logic [NUM_IRQ-1:0] sw_set;
  logic [NUM_IRQ-1:0] w1c_clr;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] set;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic [NUM_IRQ-1:0] active;

  // Vector encoder
  logic               vec_vld;
  logic [3:0]         vec_idx;

  logic [15:0]        rd_mux;

  // Upper writedata bits beyond the implemented lines are intentionally ignored.
  logic               unused_wd;
  assign unused_wd = ^writedata;

  function automatic logic [15:0] zext(input logic [NUM_IRQ-1:0] v);
    logic [15:0] r;
    r            = '0;
    r[NUM_IRQ-1:0] = v;
    return r;
  endfunction

  assign wr       = chipselect & ~write_n;
  assign wd_lines = writedata[NUM_IRQ-1:0];

  // Edge detect against last cycle's sample of the line.
  assign rise   = irq_in & ~irq_d;
  assign hw_set = (edge_sel & rise) | (~edge_sel & irq_in);

  assign sw_set  = (wr && address == ADDR_PENDING) ? wd_lines : '0;
  assign w1c_clr = (wr && address == ADDR_STATUS)  ? wd_lines : '0;

  // ACK clears one line by index; indices at or beyond NUM_IRQ match no bit and so do nothing.
  always_comb begin
    ack_clr = '0;
    if (wr && address == ADDR_ACK) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (writedata[3:0] == 4'(i)) begin
          ack_clr[i] = 1'b1;
        end
      end
    end
  end

  assign set = hw_set | sw_set;
  assign clr = w1c_clr | ack_clr;

  // Set has priority over clear so an event arriving during a clear is never dropped.
  // A level line still asserted therefore re-pends immediately after being cleared.
  assign pending_nxt = set | (pending & ~clr);

  assign active = pending & mask;

  // Lowest-numbered active line wins; scanning downward leaves the lowest index last.
  always_comb begin
    vec_vld = |active;
    vec_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        vec_idx = 4'(i);
      end
    end
  end

  // Read mux sees register state before any write landing on this same edge.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATUS:  rd_mux = zext(active);
      ADDR_PENDING: rd_mux = zext(pending);
      ADDR_MASK:    rd_mux = zext(mask);
      ADDR_EDGE:    rd_mux = zext(edge_sel);
      ADDR_VECTOR:  rd_mux = {vec_vld, 11'b0, vec_idx};
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      mask     <= '0;
      edge_sel <= RESET_EDGE;
      irq_d    <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      irq_d    <= irq_in;
      pending  <= pending_nxt;
      readdata <= rd_mux;
      irq      <= |active;
      if (wr && address == ADDR_MASK) begin
        mask <= wd_lines;
      end
      if (wr && address == ADDR_EDGE) begin
        edge_sel <= wd_lines;
      end
    end
  end

endmodule

// File: tb/tb_irq_aggregator.sv
// Purpose : self-checking bench for irq_aggregator: directed register scenarios plus random traffic
//           compared every cycle against a per-line behavioural model.
// Ports   : none (top-level bench).

module tb_irq_aggregator;

  localparam int N = 8;
  localparam logic [N-1:0] R_EDGE = 8'h00;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [15:0]   writedata;
  logic [15:0]   readdata;
  logic [N-1:0]  irq_in;
  logic          irq;

  always #5 clk = ~clk;

  irq_aggregator #(.NUM_IRQ(N), .RESET_EDGE(R_EDGE)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: one flag per line, updated by the register-level rules.
  bit           m_pend [N];
  bit           m_mask [N];
  bit           m_edge [N];
  bit           m_prev [N];
  logic [15:0]  m_rd;
  bit           m_irq;
  logic [N-1:0] cur_in = '0;

  function automatic logic [15:0] model_read(input int a);
    logic [15:0] v;
    v = 16'h0000;
    case (a)
      0: for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i]) v = v + 16'(1 << i);
      1: for (int i = 0; i < N; i++) if (m_pend[i]) v = v + 16'(1 << i);
      2: for (int i = 0; i < N; i++) if (m_mask[i]) v = v + 16'(1 << i);
      3: for (int i = 0; i < N; i++) if (m_edge[i]) v = v + 16'(1 << i);
      4: begin
        for (int i = 0; i < N; i++) begin
          if (m_pend[i] && m_mask[i]) begin
            v = 16'h8000 + 16'(i);
            break;
          end
        end
      end
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  // One bus cycle: drive, advance model, clock, compare readdata and irq.
  task automatic step(input int a, input bit cs, input bit wn, input logic [15:0] wd, input bit rst);
    bit wr;
    bit nxt [N];
    bit s, c, any;
    address    = 3'(a);
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    irq_in     = cur_in;
    reset      = rst;
    wr = cs && !wn;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_mask[i] = 0; m_edge[i] = R_EDGE[i]; m_prev[i] = 0;
      end
      m_rd  = 16'h0000;
      m_irq = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        s = m_edge[i] ? (cur_in[i] && !m_prev[i]) : cur_in[i];
        if (wr && a == 1 && wd[i]) s = 1;
        c = (wr && a == 0 && wd[i]) || (wr && a == 5 && int'(wd[3:0]) == i);
        nxt[i] = s ? 1 : (c ? 0 : m_pend[i]);
      end
      m_rd = model_read(a);
      any = 0;
      for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i]) any = 1;
      m_irq = any;
      for (int i = 0; i < N; i++) begin
        if (wr && a == 2) m_mask[i] = wd[i];
        if (wr && a == 3) m_edge[i] = wd[i];
        m_prev[i] = cur_in[i];
        m_pend[i] = nxt[i];
      end
    end
    @(posedge clk);
    #1;
    check("readdata", readdata, m_rd);
    check("irq", {15'b0, irq}, {15'b0, m_irq});
  endtask

  task automatic idle();
    step(0, 0, 1, 16'h0000, 0);
  endtask

  task automatic wr_reg(input int a, input logic [15:0] d);
    step(a, 1, 0, d, 0);
  endtask

  task automatic rd_reg(input int a, output logic [15:0] v);
    step(a, 1, 1, 16'h0000, 0);
    v = readdata;
  endtask

  task automatic do_reset();
    step(0, 0, 1, 16'h0000, 1);
    step(0, 0, 1, 16'h0000, 1);
  endtask

  logic [15:0] v;

  initial begin
    address = '0; chipselect = 0; write_n = 1; writedata = '0; irq_in = '0; reset = 1;

    // 1: level mode, line 0
    cur_in = '0;
    do_reset();
    wr_reg(2, 16'h0001);
    cur_in = 8'h01;
    idle();
    rd_reg(1, v);
    check("t1_pending", v, 16'h0001);
    check("t1_irq", {15'b0, irq}, 16'h0001);
    rd_reg(4, v);
    check("t1_vector", v, 16'h8000);
    cur_in = '0;
    wr_reg(0, 16'h0001);

    // 2: edge mode, line 2 held high, W1C while still high
    do_reset();
    wr_reg(3, 16'h0004);
    wr_reg(2, 16'h0004);
    cur_in = 8'h04;
    repeat (5) idle();
    rd_reg(1, v);
    check("t2_pending_once", v, 16'h0004);
    wr_reg(0, 16'h0004);
    rd_reg(1, v);
    check("t2_pending_clr", v, 16'h0000);
    check("t2_irq_low", {15'b0, irq}, 16'h0000);
    repeat (3) idle();
    rd_reg(1, v);
    check("t2_no_repend", v, 16'h0000);
    cur_in = '0;

    // 3: vector priority and ACK
    do_reset();
    wr_reg(1, 16'h0028);
    wr_reg(2, 16'h0028);
    rd_reg(4, v);
    check("t3_vec3", v, 16'h8003);
    wr_reg(5, 16'h0003);
    rd_reg(4, v);
    check("t3_vec5", v, 16'h8005);
    wr_reg(5, 16'h0005);
    rd_reg(4, v);
    check("t3_vec_none", v, 16'h0000);
    check("t3_irq", {15'b0, irq}, 16'h0000);

    // 4: rising edge coincides with W1C of the same line
    do_reset();
    wr_reg(3, 16'h0002);
    idle();
    cur_in = 8'h02;
    wr_reg(0, 16'h0002);
    rd_reg(1, v);
    check("t4_set_wins", v, 16'h0002);
    cur_in = '0;

    // 5: software trigger, masking, out-of-range ACK
    do_reset();
    wr_reg(1, 16'h0080);
    rd_reg(0, v);
    check("t5_status", v, 16'h0000);
    rd_reg(1, v);
    check("t5_pending", v, 16'h0080);
    check("t5_irq0", {15'b0, irq}, 16'h0000);
    wr_reg(2, 16'h0080);
    idle();
    check("t5_irq1", {15'b0, irq}, 16'h0001);
    wr_reg(5, 16'h000F);
    rd_reg(1, v);
    check("t5_ack_oor", v, 16'h0080);

    // 6: reset while irq is asserted
    check("t6_pre_irq", {15'b0, irq}, 16'h0001);
    step(1, 1, 1, 16'h0000, 1);
    check("t6_irq", {15'b0, irq}, 16'h0000);
    check("t6_readdata", readdata, 16'h0000);
    rd_reg(2, v);
    check("t6_mask", v, 16'h0000);
    rd_reg(3, v);
    check("t6_edge", v, 16'(R_EDGE));

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] wd;
      int a;
      bit rst;
      if ($urandom_range(0, 7) == 0) cur_in[$urandom_range(0, N - 1)] ^= 1'b1;
      a   = $urandom_range(0, 7);
      wd  = 16'($urandom);
      if (a == 0 || a == 5) wd = wd & 16'h00FF;
      if (a == 0 && $urandom_range(0, 1) == 0) wd = wd & 16'h000F;
      rst = ($urandom_range(0, 299) == 0);
      step(a, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), wd, rst);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
